datapath_unit: RTL

Responder side of the datapath instruction handshake: accepts one instruction per start pulse from a drawing/control FSM, executes it against a private word RAM or the VGA plot port, and returns `finished_dp`/`result_dp`. It sits between the per-object control FSMs (arbitrated upstream) and the VGA adapter and simulation memory.

---
 rtl/datapath_unit_pkg.sv | 33 +++
 rtl/datapath_unit_if.sv | 13 +
 rtl/datapath_unit_dp_ram.sv | 23 ++
 rtl/datapath_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/datapath_unit_pkg.sv
// Shared constants, opcodes, operand field positions and the instruction payload type
// for the datapath instruction handshake.
package datapath_unit_pkg;

   localparam int unsigned MEM_ADDR_WIDTH    = 16;
   localparam int unsigned RESULT_WIDTH      = 16;
   localparam int unsigned INSTRUCTION_WIDTH = 32;
   localparam int unsigned OPCODE_WIDTH      = 4;
   localparam int unsigned OPERAND_WIDTH     = INSTRUCTION_WIDTH - OPCODE_WIDTH;
   localparam int unsigned X_COORD_WIDTH     = 8;
   localparam int unsigned Y_COORD_WIDTH     = 7;
   localparam int unsigned COLOUR_WIDTH      = 3;
   localparam int unsigned WDATA_WIDTH       = 12;

   // Operand field positions
   localparam int unsigned ADDR_LSB    = 0;
   localparam int unsigned WDATA_LSB   = 16;
   localparam int unsigned X_LSB       = 0;
   localparam int unsigned Y_LSB       = 8;
   localparam int unsigned COLOUR_LSB  = 15;
   localparam int unsigned PLOT_EN_BIT = 18;

   localparam logic [OPCODE_WIDTH-1:0] OPCODE_NOP      = 4'd0;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMREAD  = 4'd1;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_MEMWRITE = 4'd2;
   localparam logic [OPCODE_WIDTH-1:0] OPCODE_DRAW     = 4'd3;

   typedef struct packed {
      logic [OPCODE_WIDTH-1:0]  opcode;
      logic [OPERAND_WIDTH-1:0] operand;
   } instruction_t;

endpackage

// File: rtl/datapath_unit_if.sv
// Start/finish instruction handshake between a control FSM (master) and the datapath (slave).
interface datapath_unit_if;
   import datapath_unit_pkg::*;

   logic                    start_dp;
   instruction_t            instruction_dp;
   logic                    finished_dp;
   logic [RESULT_WIDTH-1:0] result_dp;

   modport master (output start_dp, output instruction_dp, input finished_dp, input result_dp);
   modport slave  (input start_dp, input instruction_dp, output finished_dp, output result_dp);

endinterface

// File: rtl/datapath_unit_dp_ram.sv
// Single-port synchronous word RAM with registered read; the array has no reset.
module dp_ram #(
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/datapath_unit.sv
// Datapath responder: accepts one instruction per start_dp rising edge and executes it
// against the private word RAM or the VGA plot port, then reports finished_dp/result_dp.
module datapath_unit
   import datapath_unit_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256
) (
   input  logic                     clock,
   input  logic                     resetn,
   datapath_unit_if.slave           dp,
   output logic [X_COORD_WIDTH-1:0] vga_x,
   output logic [Y_COORD_WIDTH-1:0] vga_y,
   output logic [COLOUR_WIDTH-1:0]  vga_colour,
   output logic                     vga_plot
);

   localparam int unsigned RAM_ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_READ_WAIT,
      S_READ_CAPTURE,
      S_DONE
   } state_t;

   state_t                     state;
   logic                       start_q;
   instruction_t               instr_q;
   logic                       ram_we;
   logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
   logic [RESULT_WIDTH-1:0]    ram_wdata;
   logic [RESULT_WIDTH-1:0]    ram_rdata;
   logic                       rd_in_range;

   logic [MEM_ADDR_WIDTH-1:0]  op_addr_c;
   logic                       op_in_range_c;

   // Out-of-range addresses are flagged rather than truncated so they never alias
   assign op_addr_c     = instr_q.operand[ADDR_LSB +: MEM_ADDR_WIDTH];
   assign op_in_range_c = 32'(op_addr_c) < MEM_DEPTH;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= S_IDLE;
         start_q        <= 1'b0;
         instr_q        <= '0;
         dp.finished_dp <= 1'b1;
         dp.result_dp   <= '0;
         vga_x          <= '0;
         vga_y          <= '0;
         vga_colour     <= '0;
         vga_plot       <= 1'b0;
         ram_we         <= 1'b0;
         ram_addr       <= '0;
         ram_wdata      <= '0;
         rd_in_range    <= 1'b0;
      end else begin
         start_q  <= dp.start_dp;
         ram_we   <= 1'b0;
         vga_plot <= 1'b0;
         case (state)
            S_IDLE: begin
               // Edge-detected so a level held across completion cannot re-trigger
               if (dp.start_dp && !start_q) begin
                  instr_q        <= dp.instruction_dp;
                  dp.finished_dp <= 1'b0;
                  dp.result_dp   <= '0;
                  state          <= S_DECODE;
               end
            end
            S_DECODE: begin
               state       <= S_DONE;
               ram_addr    <= op_addr_c[RAM_ADDR_WIDTH-1:0];
               rd_in_range <= op_in_range_c;
               case (instr_q.opcode)
                  OPCODE_MEMREAD: begin
                     state <= S_READ_WAIT;
                  end
                  OPCODE_MEMWRITE: begin
                     ram_we    <= op_in_range_c;
                     ram_wdata <= RESULT_WIDTH'(instr_q.operand[WDATA_LSB +: WDATA_WIDTH]);
                  end
                  OPCODE_DRAW: begin
                     vga_x      <= instr_q.operand[X_LSB +: X_COORD_WIDTH];
                     vga_y      <= instr_q.operand[Y_LSB +: Y_COORD_WIDTH];
                     vga_colour <= instr_q.operand[COLOUR_LSB +: COLOUR_WIDTH];
                     vga_plot   <= instr_q.operand[PLOT_EN_BIT];
                  end
                  default: begin
                  end
               endcase
            end
            S_READ_WAIT: begin
               state <= S_READ_CAPTURE;
            end
            S_READ_CAPTURE: begin
               dp.result_dp <= rd_in_range ? ram_rdata : '0;
               state        <= S_DONE;
            end
            S_DONE: begin
               dp.finished_dp <= 1'b1;
               state          <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   dp_ram #(
      .DEPTH      (MEM_DEPTH),
      .ADDR_WIDTH (RAM_ADDR_WIDTH),
      .DATA_WIDTH (RESULT_WIDTH)
   ) u_dp_ram (
      .clock (clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
